alu_result_checker: RTL and testbench

- Synthesizable self-checking monitor on the ALU result side.
- Accepts one ALU transaction per cycle: operands A and B, ALU_Sel, and the ALU's observed ALU_Out, coutfin and z.
- Recomputes the expected result with an internal golden model, flags mismatches, and keeps pass/error statistics.
- Sits beside the Alu in the datapath and on FPGA bring-up builds, downstream of whatever drives the ALU.

---
 rtl/alu_result_checker.sv | 174 +++++++++++++++++
 tb/tb_alu_result_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// ALU result checker: a golden model recomputes each ALU transaction one cycle later, flags mismatches and keeps saturating pass/error statistics.
// Optional flag checking (carry-out and zero) is enabled by defining ALU_CHK_FLAGS_EN.
module alu_result_checker #(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
    input  logic [3:0]       ALU_Sel,
    input  logic [31:0]      ALU_Out,
    input  logic             coutfin,
    input  logic             z,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       first_err_sel,
    output logic [31:0]      first_err_got,
    output logic [31:0]      first_err_exp,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state, state_nx;

    logic        s1_vld;
    logic [31:0] s1_a, s1_b, s1_out;
    logic [3:0]  s1_sel;
    logic        s1_cout, s1_z;

    logic [31:0] exp_res;
    logic        exp_cout, exp_z;
    logic [32:0] sum33, sub33;
    logic        s1_mis;
    logic        halt_now;
    logic        accept;
    logic        err_seen;

    // Golden model: 33-bit unsigned arithmetic so bit 32 is the carry.
    always_comb begin
        sum33    = {1'b0, s1_a} + {1'b0, s1_b};
        sub33    = {1'b0, s1_a} + {1'b0, ~s1_b} + 33'd1;
        exp_res  = 32'd0;
        exp_cout = 1'b0;
        case (s1_sel)
            4'b0000: exp_res = s1_a & s1_b;
            4'b0001: exp_res = s1_a | s1_b;
            4'b0010: begin
                exp_res  = sum33[31:0];
                exp_cout = sum33[32];
            end
            4'b0110: begin
                exp_res  = sub33[31:0];
                exp_cout = sub33[32];
            end
            4'b0111: exp_res = ($signed(s1_a) < $signed(s1_b)) ? 32'd1 : 32'd0;
            4'b1100: exp_res = ~(s1_a | s1_b);
            default: exp_res = 32'd0;
        endcase
        exp_z = (exp_res == 32'd0);
    end

`ifdef ALU_CHK_FLAGS_EN
    assign s1_mis = (s1_out != exp_res) || (s1_cout != exp_cout) || (s1_z != exp_z);
`else
    logic unused_flags;
    assign unused_flags = &{1'b0, s1_cout, s1_z, exp_cout, exp_z};
    assign s1_mis = (s1_out != exp_res);
`endif

    // A failing check that will halt the checker also refuses the sample offered alongside it.
    assign halt_now = STOP_ON_ERR && s1_vld && s1_mis;
    assign in_ready = (state != HALT) && !halt_now;
    assign accept   = in_valid && in_ready && !clear;
    assign halted   = (state == HALT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     state_nx = RUN;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
        if (halt_now) state_nx = HALT;
        if (clear)    state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // S1 capture stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_sel  <= '0;
            s1_out  <= '0;
            s1_cout <= 1'b0;
            s1_z    <= 1'b0;
        end else if (clear) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_sel  <= '0;
            s1_out  <= '0;
            s1_cout <= 1'b0;
            s1_z    <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a    <= A;
                s1_b    <= B;
                s1_sel  <= ALU_Sel;
                s1_out  <= ALU_Out;
                s1_cout <= coutfin;
                s1_z    <= z;
            end
        end
    end

    // Check results, statistics and first-error capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_valid     <= 1'b0;
            mismatch      <= 1'b0;
            pass_count    <= '0;
            err_count     <= '0;
            first_err_sel <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            err_seen      <= 1'b0;
        end else if (clear) begin
            chk_valid     <= 1'b0;
            mismatch      <= 1'b0;
            pass_count    <= '0;
            err_count     <= '0;
            first_err_sel <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            err_seen      <= 1'b0;
        end else begin
            chk_valid <= s1_vld;
            mismatch  <= s1_vld && s1_mis;
            if (s1_vld) begin
                if (s1_mis) begin
                    if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
                    if (!err_seen) begin
                        err_seen      <= 1'b1;
                        first_err_sel <= s1_sel;
                        first_err_got <= s1_out;
                        first_err_exp <= exp_res;
                    end
                end else if (pass_count != {CNT_W{1'b1}}) begin
                    pass_count <= pass_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: default, STOP_ON_ERR=1 and CNT_W=4 instances share one stimulus stream.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid;
    logic [31:0] A, B, ALU_Out;
    logic [3:0]  ALU_Sel;
    logic        coutfin, z;

    logic        d_rdy, d_cv, d_mis, d_halt;
    logic [15:0] d_pass, d_err;
    logic [3:0]  d_fsel;
    logic [31:0] d_fgot, d_fexp;

    logic        s_rdy, s_cv, s_mis, s_halt;
    logic [15:0] s_pass, s_err;
    logic [3:0]  s_fsel;
    logic [31:0] s_fgot, s_fexp;

    logic        t_rdy, t_cv, t_mis, t_halt;
    logic [3:0]  t_pass, t_err;
    logic [3:0]  t_fsel;
    logic [31:0] t_fgot, t_fexp;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_result_checker u_dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .coutfin(coutfin), .z(z),
        .chk_valid(d_cv), .mismatch(d_mis), .pass_count(d_pass), .err_count(d_err),
        .first_err_sel(d_fsel), .first_err_got(d_fgot), .first_err_exp(d_fexp), .halted(d_halt)
    );

    alu_result_checker #(.STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(s_rdy),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .coutfin(coutfin), .z(z),
        .chk_valid(s_cv), .mismatch(s_mis), .pass_count(s_pass), .err_count(s_err),
        .first_err_sel(s_fsel), .first_err_got(s_fgot), .first_err_exp(s_fexp), .halted(s_halt)
    );

    alu_result_checker #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(t_rdy),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .coutfin(coutfin), .z(z),
        .chk_valid(t_cv), .mismatch(t_mis), .pass_count(t_pass), .err_count(t_err),
        .first_err_sel(t_fsel), .first_err_got(t_fgot), .first_err_exp(t_fexp), .halted(t_halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] o, input logic c, input logic zz);
        @(negedge clk);
        in_valid = 1'b1;
        ALU_Sel  = sel;
        A        = a;
        B        = b;
        ALU_Out  = o;
        coutfin  = c;
        z        = zz;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        A = '0; B = '0; ALU_Sel = '0; ALU_Out = '0; coutfin = 1'b0; z = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_chk_valid", {31'd0, d_cv}, 32'd0);
        check("rst_in_ready", {31'd0, d_rdy}, 32'd1);
        check("rst_halted", {31'd0, s_halt}, 32'd0);
        check("rst_pass", {16'd0, d_pass}, 32'd0);
        reset = 1'b0;

        // single AND transaction
        drive(4'b0000, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1);
        idle();
        check("and_no_early", {31'd0, d_cv}, 32'd0);
        idle();
        check("and_chk_valid", {31'd0, d_cv}, 32'd1);
        check("and_mismatch", {31'd0, d_mis}, 32'd0);
        check("and_pass", {16'd0, d_pass}, 32'd1);
        idle();
        check("and_pulse_end", {31'd0, d_cv}, 32'd0);

        // back-to-back OR, ADD, undefined op
        do_clear();
        drive(4'b0001, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
        drive(4'b0010, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0);
        drive(4'b1111, 32'h5, 32'h6, 32'h0, 1'b0, 1'b1);
        check("b2b_cv0", {31'd0, d_cv}, 32'd1);
        idle();
        check("b2b_cv1", {31'd0, d_cv}, 32'd1);
        idle();
        check("b2b_cv2", {31'd0, d_cv}, 32'd1);
        check("b2b_pass", {16'd0, d_pass}, 32'd3);
        check("b2b_err", {16'd0, d_err}, 32'd0);
        idle();
        check("b2b_cv_end", {31'd0, d_cv}, 32'd0);

        // SUB and SLT, including signed compare of a negative operand
        do_clear();
        drive(4'b0110, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        drive(4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
        drive(4'b1100, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        check("sub_slt_nor_pass", {16'd0, d_pass}, 32'd3);
        check("sub_slt_nor_err", {16'd0, d_err}, 32'd0);

        // ADD overflow with carry-out reported as 0
        do_clear();
        drive(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1);
        idle();
        idle();
`ifdef ALU_CHK_FLAGS_EN
        check("carry_mismatch", {31'd0, d_mis}, 32'd1);
        check("carry_err", {16'd0, d_err}, 32'd1);
`else
        check("carry_mismatch", {31'd0, d_mis}, 32'd0);
        check("carry_pass", {16'd0, d_pass}, 32'd1);
`endif

        // stop on error: follow-on sample refused, failure captured
        do_clear();
        drive(4'b0000, 32'hF, 32'hF, 32'hE, 1'b0, 1'b0);
        drive(4'b0000, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0);
        check("stop_refuse_rdy", {31'd0, s_rdy}, 32'd0);
        idle();
        check("stop_cv", {31'd0, s_cv}, 32'd1);
        check("stop_mis", {31'd0, s_mis}, 32'd1);
        check("stop_got", s_fgot, 32'hE);
        check("stop_exp", s_fexp, 32'hF);
        check("stop_sel", {28'd0, s_fsel}, 32'd0);
        check("stop_halted", {31'd0, s_halt}, 32'd1);
        check("stop_in_ready", {31'd0, s_rdy}, 32'd0);
        check("stop_err", {16'd0, s_err}, 32'd1);
        check("nostop_rdy", {31'd0, d_rdy}, 32'd1);
        idle();
        check("stop_no_2nd_chk", {31'd0, s_cv}, 32'd0);
        check("stop_pass", {16'd0, s_pass}, 32'd0);
        check("nostop_pass", {16'd0, d_pass}, 32'd1);
        do_clear();
        check("clr_halted", {31'd0, s_halt}, 32'd0);
        check("clr_in_ready", {31'd0, s_rdy}, 32'd1);
        check("clr_err", {16'd0, s_err}, 32'd0);
        check("clr_first_got", s_fgot, 32'd0);

        // clear together with a valid sample: sample dropped
        @(negedge clk);
        in_valid = 1'b1; clear = 1'b1;
        ALU_Sel = 4'b0000; A = 32'h1; B = 32'h1; ALU_Out = 32'h1;
        idle();
        clear = 1'b0;
        idle();
        check("clr_win_cv", {31'd0, d_cv}, 32'd0);
        check("clr_win_pass", {16'd0, d_pass}, 32'd0);

        // 17 failures: CNT_W=4 saturates, first error holds the first sample
        drive(4'b0000, 32'hF, 32'hF, 32'h1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(4'b0000, 32'hF, 32'hF, 32'h2, 1'b0, 1'b0);
        idle();
        idle();
        check("sat_err4", {28'd0, t_err}, 32'hF);
        check("sat_err16", {16'd0, d_err}, 32'd17);
        check("hold_first_got", d_fgot, 32'h1);
        check("hold_first_exp", d_fexp, 32'hF);

        // reset one cycle after an accepted transaction
        drive(4'b0000, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("rst_mid_cv", {31'd0, d_cv}, 32'd0);
        check("rst_mid_pass", {16'd0, d_pass}, 32'd0);
        check("rst_mid_err", {16'd0, d_err}, 32'd0);
        check("rst_mid_fgot", d_fgot, 32'd0);
        reset = 1'b0;
        idle();
        check("rst_mid_no_pulse", {31'd0, d_cv}, 32'd0);
        check("rst_mid_rdy", {31'd0, s_rdy}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
